piso_tx: RTL and testbench

//  Parallel-in/serial-out transmitter; the unload-side counterpart of the datapath PIPO registers.

---
 rtl/piso_tx.sv | 178 +++++++++++++++++
 tb/tb_piso_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx : parallel-in / serial-out transmitter
//
// Takes a WIDTH-bit word on the ld/rdy handshake and sends it one bit per
// clock on sout. sval marks every valid serial bit. done pulses for one cycle
// after the last bit of a frame.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When defined, an even-parity bit of the loaded word follows the data bits
//   (state PAR, sval=1), so a frame is one cycle longer.
//   When undefined, there is no PAR state and no parity register.
//
// Parameters
//   WIDTH       data word width, WIDTH >= 2
//   MSB_FIRST   1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//
// Ports
//   clk          in   clock, all logic on posedge
//   clr_n        in   asynchronous active-low reset
//   din          in   parallel word, sampled only on an accepted load
//   ld           in   load request
//   rdy          out  high only in IDLE
//   sout         out  serial data bit
//   sval         out  high while sout carries a valid bit
//   done         out  one-cycle pulse after the final bit
//   dbg_state_o  out  current FSM state (IDLE=0, SHIFT=1, PAR=2, DONE=3)
//
// Handshake: a word is accepted on the rising edge where ld=1 and rdy=1.
// ld while rdy=0 is ignored; nothing is queued. If ld stays high, the next
// word is taken on the first edge at which rdy is high again.
// ---------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  output logic             rdy,
  output logic             sout,
  output logic             sval,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd3
  } state_e;
`endif

  state_e            state_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [CW-1:0]     cnt_q;
  logic              rdy_q;
  logic              sout_q;
  logic              sval_q;
  logic              done_q;
`ifdef PISO_PARITY_EN
  logic              par_q;
`endif

  // Shift register after one shift toward the output end, zero-filled.
  logic [WIDTH-1:0]  shreg_d;
  // Bit that will sit at the output end after the shift; sout is registered,
  // so it is loaded with this value one edge ahead of the shift register.
  logic              next_bit_d;
  // Output-end bit of the incoming word, used on the load edge.
  logic              load_bit_d;

  always_comb begin
    shreg_d    = '0;
    next_bit_d = 1'b0;
    load_bit_d = 1'b0;
    if (MSB_FIRST) begin
      shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
      next_bit_d = shreg_q[WIDTH-2];
      load_bit_d = din[WIDTH-1];
    end else begin
      shreg_d    = {1'b0, shreg_q[WIDTH-1:1]};
      next_bit_d = shreg_q[1];
      load_bit_d = din[0];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      sout_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld) begin
            shreg_q <= din;
            cnt_q   <= '0;
            state_q <= S_SHIFT;
            rdy_q   <= 1'b0;
            sval_q  <= 1'b1;
            sout_q  <= load_bit_d;
`ifdef PISO_PARITY_EN
            par_q   <= ^din;
`endif
          end
        end

        S_SHIFT: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            // sval stays high: the parity bit is a valid serial bit.
            state_q <= S_PAR;
            sout_q  <= par_q;
`else
            state_q <= S_DONE;
            sval_q  <= 1'b0;
            sout_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            sout_q <= next_bit_d;
          end
        end

`ifdef PISO_PARITY_EN
        S_PAR: begin
          state_q <= S_DONE;
          sval_q  <= 1'b0;
          sout_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
          sout_q  <= 1'b0;
          sval_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rdy         = rdy_q;
  assign sout        = sout_q;
  assign sval        = sval_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  localparam int W = 16;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] din = '0;
  logic         ld  = 1'b0;

  logic       rdy_m, sout_m, sval_m, done_m;
  logic       rdy_l, sout_l, sval_l, done_l;
  logic [1:0] dbg_m, dbg_l;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr_n(clr_n), .din(din), .ld(ld),
    .rdy(rdy_m), .sout(sout_m), .sval(sval_m), .done(done_m),
    .dbg_state_o(dbg_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr_n(clr_n), .din(din), .ld(ld),
    .rdy(rdy_l), .sout(sout_l), .sval(sval_l), .done(done_l),
    .dbg_state_o(dbg_l)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame accepted at edge k occupies offsets d = c-k (c = index of the
  // last edge before the sample): data bits at d=0..W-1, parity (if built)
  // at d=W, done at d=W+P, idle afterwards. Next accept needs e-k >= W+P+2.
  int           cyc     = 0;
  bit           m_busy  = 1'b0;
  int           m_k     = 0;
  logic [W-1:0] m_word  = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_busy <= 1'b0;
      exp_q.delete();
    end else if (ld && (!m_busy || (cyc - m_k) >= W + P + 2)) begin
      m_busy <= 1'b1;
      m_k    <= cyc;
      m_word <= din;
      exp_q.push_back(din);
    end
  end

  // returns {rdy, sval, sout, done}
  function automatic logic [3:0] model_out(input int c, input bit msb);
    int d;
    logic [3:0] r;
    r = 4'b1000;
    if (m_busy) begin
      d = c - m_k;
      if (d >= 0 && d < W)
        r = {1'b0, 1'b1, (msb ? m_word[W-1-d] : m_word[d]), 1'b0};
      else if (P == 1 && d == W)
        r = {1'b0, 1'b1, ^m_word, 1'b0};
      else if (d == W + P)
        r = 4'b0001;
    end
    return r;
  endfunction

  bit chk_en = 1'b0;

  task automatic check_outputs(input string pfx);
    logic [3:0] em, el;
    em = model_out(cyc - 1, 1'b1);
    el = model_out(cyc - 1, 1'b0);
    check({pfx, "msb_rdy"},  rdy_m,  em[3]);
    check({pfx, "msb_sval"}, sval_m, em[2]);
    check({pfx, "msb_sout"}, sout_m, em[1]);
    check({pfx, "msb_done"}, done_m, em[0]);
    check({pfx, "lsb_rdy"},  rdy_l,  el[3]);
    check({pfx, "lsb_sval"}, sval_l, el[2]);
    check({pfx, "lsb_sout"}, sout_l, el[1]);
    check({pfx, "lsb_done"}, done_l, el[0]);
  endtask

  always @(negedge clk) if (chk_en) check_outputs("cyc_");

  // ---------------- frame scoreboard (MSB instance) ----------------
  logic [W-1:0] got       = '0;
  logic [W-1:0] last_word = '0;
  int           nbits     = 0;
  int           done_cnt  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!clr_n) begin
        nbits = 0;
      end else begin
        if (sval_m && nbits < W) begin
          got   = {got[W-2:0], sout_m};
          nbits = nbits + 1;
        end
        if (done_m) begin
          done_cnt = done_cnt + 1;
          if (exp_q.size() == 0) check("done_without_frame", 1, 0);
          else begin
            check("frame_word", got, exp_q.pop_front());
            check("frame_bits", nbits, W);
          end
          last_word = got;
          nbits     = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic l, input logic [W-1:0] d);
    ld  = l;
    din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, W'($urandom));
  endtask

  task automatic wait_idle();
    int i;
    ld = 1'b0;
    for (i = 0; i < 60 && !rdy_m; i++) begin
      @(posedge clk);
      #2;
    end
    check("idle_timeout", rdy_m, 1);
  endtask

  // asynchronous reset in the middle of a clock period
  task automatic reset_mid();
    #1 clr_n = 1'b0;
    #1;
    check_outputs("rst_");
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    clr_n = 1'b1;
  endtask

  task automatic one_frame(input string tag, input logic [W-1:0] d);
    int dc;
    dc = done_cnt;
    drive(1'b1, d);
    idle(W + 4);
    check({tag, "_word"}, last_word, d);
    check({tag, "_dones"}, done_cnt - dc, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("rst_state_msb", dbg_m, 0);
    check("rst_state_lsb", dbg_l, 0);
    check("rst_rdy", rdy_m, 1);
    clr_n = 1'b1;
    idle(2);

    // single frames (MSB and LSB instances see the same word)
    one_frame("a5c3", 16'hA5C3);
    one_frame("par1", 16'h0001);
    one_frame("par0", 16'h0003);

    // load while busy is ignored
    dc = done_cnt;
    drive(1'b1, 16'h00FF);
    idle(4);
    drive(1'b1, 16'hFFFF);
    idle(W + 4);
    check("busy_word", last_word, 16'h00FF);
    check("busy_dones", done_cnt - dc, 1);

    // back-to-back with ld held high
    dc = done_cnt;
    drive(1'b1, 16'h8001);
    for (int i = 0; i < W + P + 2; i++) drive(1'b1, 16'h7FFE);
    idle(W + 5);
    check("b2b_word", last_word, 16'h7FFE);
    check("b2b_dones", done_cnt - dc, 2);

    // reset mid-frame: aborted frame, then a clean one
    dc = done_cnt;
    drive(1'b1, 16'h1234);
    idle(7);
    reset_mid();
    check("abort_dones", done_cnt - dc, 0);
    one_frame("after_rst", 16'hBEEF);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) reset_mid();
      else drive($urandom_range(0, 3) == 0, W'($urandom));
    end

    wait_idle();
    idle(3);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
